fir_tap_sequencer: RTL and testbench

Sequencer that drives the FIR datapath's multiply-accumulate unit. It accepts one input sample per handshake and shifts it into a TAPS-deep sample delay line. It then streams TAPS (sample, coefficient) operand pairs to the MAC, one per clock, with first/last markers so the MAC restarts accumulation for each output sample. Coefficients are held in a register bank that the host can write at any time.

---
 rtl/fir_tap_sequencer.sv | 111 +++++++++++
 tb/tb_fir_tap_sequencer.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fir_tap_sequencer.sv
// fir_tap_sequencer: feeds a multiply-accumulate unit.
// It takes one input sample and shifts it into a TAPS-deep delay line.
// It then streams TAPS (sample, coefficient) operand pairs, one per clock.
// Each burst carries first/last markers so the MAC restarts accumulation per output.
// Coefficients sit in a register bank that the host may rewrite at any time.
module fir_tap_sequencer #(
  parameter int N    = 8,
  parameter int TAPS = 4,
  localparam int CW  = ($clog2(TAPS) < 1) ? 1 : $clog2(TAPS)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [N-1:0]  in_data,
  input  logic          coef_we,
  input  logic [CW-1:0] coef_addr,
  input  logic [N-1:0]  coef_data,
  output logic [N-1:0]  mac_a,
  output logic [N-1:0]  mac_b,
  output logic          mac_valid,
  output logic          mac_first,
  output logic          mac_last,
  output logic          busy
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] RUN  = 1'b1;

  logic [0:0]    state;
  logic [CW-1:0] k;
  logic [N-1:0]  dly  [TAPS];
  logic [N-1:0]  coef [TAPS];

  logic accept;
  logic last_tap;
  logic coef_hit;

  assign in_ready = (state == IDLE);
  assign busy     = (state == RUN);
  assign accept   = in_valid & in_ready;
  assign last_tap = (k == CW'(TAPS - 1));
  // Out-of-range addresses are possible whenever TAPS is not a power of two.
  assign coef_hit = coef_we && ({1'b0, coef_addr} < (CW + 1)'(TAPS));

  // Control: IDLE waits for a sample, RUN walks k across all taps once.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      k     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            k     <= '0;
            state <= RUN;
          end
        end
        RUN: begin
          if (last_tap) begin
            state <= IDLE;
          end else begin
            k <= k + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Delay line: shifts only on an accepted sample, frozen during RUN.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int j = 0; j < TAPS; j++) dly[j] <= '0;
    end else if (accept) begin
      for (int j = TAPS - 1; j > 0; j--) dly[j] <= dly[j-1];
      dly[0] <= in_data;
    end
  end

  // Coefficient bank: a same-edge write to the tap being issued lands after the read.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int j = 0; j < TAPS; j++) coef[j] <= '0;
    end else if (coef_hit) begin
      coef[coef_addr] <= coef_data;
    end
  end

  // Operand stage: registered pair plus markers toward the MAC.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mac_a     <= '0;
      mac_b     <= '0;
      mac_valid <= 1'b0;
      mac_first <= 1'b0;
      mac_last  <= 1'b0;
    end else if (state == RUN) begin
      mac_a     <= dly[k];
      mac_b     <= coef[k];
      mac_valid <= 1'b1;
      mac_first <= (k == '0);
      mac_last  <= last_tap;
    end else begin
      mac_valid <= 1'b0;
      mac_first <= 1'b0;
      mac_last  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_fir_tap_sequencer.sv
// Bench for fir_tap_sequencer. It runs a 4-tap instance and a 6-tap instance.
// The 6-tap instance covers the out-of-range coefficient addresses.
module tb_fir_tap_sequencer;

  typedef struct packed {
    logic [7:0] a;
    logic [7:0] b;
    logic       f;
    logic       l;
  } op_t;

  typedef struct {
    logic [7:0] din;
    logic [7:0] ea [4];
    logic [7:0] eb [4];
  } vec_t;

  logic clk = 1'b0;
  logic reset = 1'b0;

  logic       in_valid4 = 1'b0, in_ready4, coef_we4 = 1'b0;
  logic [7:0] in_data4 = '0, coef_data4 = '0;
  logic [1:0] coef_addr4 = '0;
  logic [7:0] mac_a4, mac_b4;
  logic       mac_valid4, mac_first4, mac_last4, busy4;

  logic       in_valid6 = 1'b0, in_ready6, coef_we6 = 1'b0;
  logic [7:0] in_data6 = '0, coef_data6 = '0;
  logic [2:0] coef_addr6 = '0;
  logic [7:0] mac_a6, mac_b6;
  logic       mac_valid6, mac_first6, mac_last6, busy6;

  int nchk = 0;
  int npass = 0;
  op_t q4[$];
  op_t q6[$];
  vec_t tbl [4];

  always #5 clk = ~clk;

  fir_tap_sequencer #(.N(8), .TAPS(4)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid4), .in_ready(in_ready4), .in_data(in_data4),
    .coef_we(coef_we4), .coef_addr(coef_addr4), .coef_data(coef_data4),
    .mac_a(mac_a4), .mac_b(mac_b4), .mac_valid(mac_valid4),
    .mac_first(mac_first4), .mac_last(mac_last4), .busy(busy4)
  );

  fir_tap_sequencer #(.N(8), .TAPS(6)) dut6 (
    .clk(clk), .reset(reset),
    .in_valid(in_valid6), .in_ready(in_ready6), .in_data(in_data6),
    .coef_we(coef_we6), .coef_addr(coef_addr6), .coef_data(coef_data6),
    .mac_a(mac_a6), .mac_b(mac_b6), .mac_valid(mac_valid6),
    .mac_first(mac_first6), .mac_last(mac_last6), .busy(busy6)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    nchk++;
    if (act === exp) npass++;
    else $display("FAIL %s: got %0h, required %0h at %0t", name, act, exp, $time);
  endtask

  task automatic exp4(input logic [7:0] a, input logic [7:0] b, input logic f, input logic l);
    op_t e;
    e = '{a: a, b: b, f: f, l: l};
    q4.push_back(e);
  endtask

  task automatic push_vec(input int i);
    for (int t = 0; t < 4; t++) exp4(tbl[i].ea[t], tbl[i].eb[t], t == 0, t == 3);
  endtask

  task automatic set_vec(input int i, input logic [7:0] din,
                         input logic [7:0] a0, a1, a2, a3,
                         input logic [7:0] b0, b1, b2, b3);
    tbl[i].din = din;
    tbl[i].ea[0] = a0; tbl[i].ea[1] = a1; tbl[i].ea[2] = a2; tbl[i].ea[3] = a3;
    tbl[i].eb[0] = b0; tbl[i].eb[1] = b1; tbl[i].eb[2] = b2; tbl[i].eb[3] = b3;
  endtask

  // All tasks below start and end at 1 time unit after a rising edge.
  task automatic wr4(input logic [1:0] addr, input logic [7:0] data);
    coef_we4 = 1'b1; coef_addr4 = addr; coef_data4 = data;
    @(posedge clk); #1;
    coef_we4 = 1'b0;
  endtask

  task automatic wr6(input logic [2:0] addr, input logic [7:0] data);
    coef_we6 = 1'b1; coef_addr6 = addr; coef_data6 = data;
    @(posedge clk); #1;
    coef_we6 = 1'b0;
  endtask

  task automatic wait_ready4();
    int n = 0;
    while (!in_ready4 && n < 50) begin
      @(posedge clk); #1; n++;
    end
    check("in_ready4 before accept", in_ready4, 1'b1);
  endtask

  task automatic send4(input logic [7:0] din);
    wait_ready4();
    in_valid4 = 1'b1; in_data4 = din;
    @(posedge clk); #1;
    in_valid4 = 1'b0;
  endtask

  task automatic drain(input int which);
    int n = 0;
    while (((which == 4) ? q4.size() : q6.size()) != 0 && n < 100) begin
      @(posedge clk); #1; n++;
    end
    check((which == 4) ? "drain dut4" : "drain dut6",
          (which == 4) ? q4.size() : q6.size(), 0);
    @(posedge clk); #1;
  endtask

  // Scoreboard monitors: every valid pair must match the head of its queue.
  always @(negedge clk) begin
    if (mac_valid4) begin
      if (q4.size() == 0) check("dut4 unexpected pair", {mac_a4, mac_b4, mac_first4, mac_last4}, 64'hdead);
      else check("dut4 pair", {mac_a4, mac_b4, mac_first4, mac_last4}, q4.pop_front());
    end
    if (mac_valid6) begin
      if (q6.size() == 0) check("dut6 unexpected pair", {mac_a6, mac_b6, mac_first6, mac_last6}, 64'hdead);
      else check("dut6 pair", {mac_a6, mac_b6, mac_first6, mac_last6}, q6.pop_front());
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    op_t e;
    set_vec(0, 8'd5, 8'd5, 8'd0, 8'd0, 8'd0, 8'd1, 8'd2, 8'd3, 8'd4);
    set_vec(1, 8'd2, 8'd2, 8'd0, 8'd0, 8'd0, 8'd1, 8'd1, 8'd1, 8'd1);
    set_vec(2, 8'd3, 8'd3, 8'd2, 8'd0, 8'd0, 8'd1, 8'd1, 8'd1, 8'd1);
    set_vec(3, 8'd6, 8'd6, 8'd3, 8'd2, 8'd0, 8'd1, 8'd1, 8'd1, 8'd1);

    // Reset held for three cycles with in_valid toggling.
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      in_valid4 = ~in_valid4; in_valid6 = ~in_valid6;
      in_data4 = 8'(i + 1); in_data6 = 8'(i + 1);
      @(negedge clk);
      check("reset outputs dut4",
            {in_ready4, busy4, mac_valid4, mac_first4, mac_last4, mac_a4, mac_b4}, {5'b10000, 16'h0});
    end
    check("reset outputs dut6",
          {in_ready6, busy6, mac_valid6, mac_first6, mac_last6, mac_a6, mac_b6}, {5'b10000, 16'h0});
    in_valid4 = 1'b0; in_valid6 = 1'b0;
    reset = 1'b1;
    @(posedge clk); #1;
    check("idle after release", {in_ready4, busy4, mac_valid4}, 3'b100);

    // Single impulse with coef {1,2,3,4}.
    for (int k = 0; k < 4; k++) wr4(2'(k), 8'(k + 1));
    push_vec(0);
    send4(tbl[0].din);
    drain(4);

    // Fresh state, coef all ones, stream 2,3,6 with in_valid held high.
    @(negedge clk); reset = 1'b0;
    @(negedge clk); reset = 1'b1;
    @(posedge clk); #1;
    for (int k = 0; k < 4; k++) wr4(2'(k), 8'd1);
    in_valid4 = 1'b1;
    for (int i = 1; i < 4; i++) begin
      in_data4 = tbl[i].din;
      push_vec(i);
      wait_ready4();
      @(posedge clk); #1;
      if (i == 3) in_valid4 = 1'b0;
      n = 0;
      while (!in_ready4 && n < 20) begin
        n++; @(posedge clk); #1;
      end
      check("in_ready low cycles", n, 4);
    end
    drain(4);

    // Write coef[2]=9 on the edge that issues tap 2: dly is {7,6,3,2}.
    exp4(8'd7, 8'd1, 1'b1, 1'b0); exp4(8'd6, 8'd1, 1'b0, 1'b0);
    exp4(8'd3, 8'd1, 1'b0, 1'b0); exp4(8'd2, 8'd1, 1'b0, 1'b1);
    wait_ready4();
    in_valid4 = 1'b1; in_data4 = 8'd7;
    @(posedge clk); #1; in_valid4 = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("busy during burst", busy4, 1'b1);
    wr4(2'd2, 8'd9);
    drain(4);
    exp4(8'd8, 8'd1, 1'b1, 1'b0); exp4(8'd7, 8'd1, 1'b0, 1'b0);
    exp4(8'd6, 8'd9, 1'b0, 1'b0); exp4(8'd3, 8'd1, 1'b0, 1'b1);
    send4(8'd8);
    drain(4);

    // Reset after the second pair of a burst.
    exp4(8'd10, 8'd1, 1'b1, 1'b0); exp4(8'd8, 8'd1, 1'b0, 1'b0);
    wait_ready4();
    in_valid4 = 1'b1; in_data4 = 8'd10;
    @(posedge clk); #1; in_valid4 = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(negedge clk); #1;
    check("pairs seen before abort", q4.size(), 0);
    reset = 1'b0;
    #1;
    check("abort drops valid", {mac_valid4, mac_first4, mac_last4, busy4, in_ready4}, 5'b00001);
    @(posedge clk); #1;
    check("valid stays low in reset", mac_valid4, 1'b0);
    @(negedge clk); reset = 1'b1;
    @(posedge clk); #1;
    exp4(8'd11, 8'd0, 1'b1, 1'b0); exp4(8'd0, 8'd0, 1'b0, 1'b0);
    exp4(8'd0, 8'd0, 1'b0, 1'b0); exp4(8'd0, 8'd0, 1'b0, 1'b1);
    send4(8'd11);
    drain(4);

    // Six taps: addresses 6 and 7 are out of range and must be ignored.
    for (int k = 0; k < 6; k++) wr6(3'(k), 8'(k + 1));
    wr6(3'd7, 8'hff);
    wr6(3'd6, 8'hee);
    for (int t = 0; t < 6; t++) begin
      e = '{a: (t == 0) ? 8'd9 : 8'd0, b: 8'(t + 1), f: t == 0, l: t == 5};
      q6.push_back(e);
    end
    check("dut6 ready", in_ready6, 1'b1);
    in_valid6 = 1'b1; in_data6 = 8'd9;
    @(posedge clk); #1; in_valid6 = 1'b0;
    drain(6);

    repeat (3) @(posedge clk);
    #1;
    check("no stray pairs", {mac_valid4, mac_valid6, 8'(q4.size()), 8'(q6.size())}, 0);
    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end

endmodule
